pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. It combines the hazard unit's `hazard_detected`, the EXE-stage branch decision and the multi-cycle data-memory handshake into per-stage freeze, flush and bubble controls. A three-state FSM holds the whole pipeline during memory accesses, with a timeout and a saturating stall-cycle counter.

---
 rtl/pipeline_stall_controller.sv | 121 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch and
// multi-cycle memory handshake into per-stage freeze/flush/bubble controls.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             mem_start,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_all,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   tcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic tcnt_clr, tcnt_inc, err_set, ctrl_en, hazard_stall, stall_inc;

    always_comb begin
        state_d       = state_q;
        tcnt_clr      = 1'b0;
        tcnt_inc      = 1'b0;
        err_set       = 1'b0;
        ctrl_en       = 1'b0;
        hazard_stall  = 1'b0;
        mem_start     = 1'b0;
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        freeze_all    = 1'b0;
        if (rst) begin
            case (state_q)
                S_RUN: begin
                    if (mem_req) begin
                        mem_start  = 1'b1;
                        freeze_all = 1'b1;
                        tcnt_clr   = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        ctrl_en = 1'b1;
                    end
                end
                S_WAIT: begin
                    // hazard/branch are re-presented after release, so ignore them here
                    freeze_all = 1'b1;
                    if (mem_ready) begin
                        state_d = S_RELEASE;
                    end else if (tcnt_q == TO_LAST) begin
                        err_set = 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
                S_RELEASE: begin
                    // mem_req still shows the retiring instruction; do not relaunch
                    ctrl_en = 1'b1;
                    state_d = S_RUN;
                end
                default: state_d = S_RUN;
            endcase

            if (ctrl_en) begin
                if (branch_taken) begin
                    flush_if_id   = 1'b1;
                    bubble_id_exe = 1'b1;
                end else if (hazard_detected) begin
                    freeze_pc     = 1'b1;
                    freeze_if_id  = 1'b1;
                    bubble_id_exe = 1'b1;
                    hazard_stall  = 1'b1;
                end
            end
        end
    end

    assign stall_inc    = freeze_all | hazard_stall;
    assign mem_error    = rst & err_q;
    assign stall_cycles = rst ? cnt_q : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            tcnt_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tcnt_clr)
                tcnt_q <= '0;
            else if (tcnt_inc)
                tcnt_q <= tcnt_q + TO_W'(1);
            if (err_set)
                err_q <= 1'b1;
            if (stall_inc && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_stall_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             hazard_detected, branch_taken, mem_req, mem_ready;
    logic             mem_start, freeze_pc, freeze_if_id, flush_if_id;
    logic             bubble_id_exe, freeze_all, mem_error;
    logic [CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_start(mem_start), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
        .flush_if_id(flush_if_id), .bubble_id_exe(bubble_id_exe),
        .freeze_all(freeze_all), .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // {mem_start, freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_all, mem_error}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_HAZ  = 7'b0110100;
    localparam logic [6:0] O_BR   = 7'b0001100;
    localparam logic [6:0] O_ST   = 7'b1000010;
    localparam logic [6:0] O_FRZ  = 7'b0000010;
    localparam logic [6:0] O_ERR  = 7'b0000001;

    logic [6:0] outs;
    assign outs = {mem_start, freeze_pc, freeze_if_id, flush_if_id,
                   bubble_id_exe, freeze_all, mem_error};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic h, input logic b,
                         input logic q, input logic y);
        rst = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y;
        #1;
    endtask

    task automatic chk_o(input string tag, input logic [6:0] exp);
        checks++;
        assert (outs === exp) else begin
            failures++;
            $error("FAIL %s outs=%b expected=%b", tag, outs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [CNT_W-1:0] exp);
        checks++;
        assert (stall_cycles === exp) else begin
            failures++;
            $error("FAIL %s stall_cycles=%0d expected=%0d", tag, stall_cycles, exp);
        end
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        // reset held 3 cycles with every input high
        for (int i = 0; i < 3; i++) begin
            chk_o("rst_outs", O_NONE);
            chk_c("rst_cnt", 4'd0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("post_rst_run", O_NONE);
        tick();

        // load: req at t (ready also high at t, must be ignored), ready at t+3
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_o("ld_t_start", O_ST);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_o("ld_t1_wait", O_FRZ);
        tick();
        chk_o("ld_t2_wait", O_FRZ);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_o("ld_t3_wait", O_FRZ);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_o("ld_t4_release", O_NONE);
        chk_c("ld_cnt", 4'd4);
        tick();
        // back-to-back: next RUN cycle accepts a fresh request
        chk_o("b2b_relaunch", O_ST);
        chk_c("b2b_cnt_pre", 4'd4);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_o("b2b_wait", O_FRZ);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("b2b_release", O_NONE);
        chk_c("b2b_cnt", 4'd6);
        tick();

        // hazard x2 then hazard+branch
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_o("haz_1", O_HAZ);
        chk_c("haz_cnt0", 4'd0);
        tick();
        chk_o("haz_2", O_HAZ);
        chk_c("haz_cnt1", 4'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_o("haz_br", O_BR);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_c("haz_cnt", 4'd2);
        chk_o("haz_idle", O_NONE);
        tick();

        // branch during WAIT is ignored, honoured in RELEASE
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_o("brw_start", O_ST);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_o("brw_wait", O_FRZ);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_o("brw_wait_rdy", O_FRZ);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_o("brw_release", O_BR);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_o("brw_run_haz", O_HAZ);
        tick();

        // timeout: MEM_TIMEOUT=4, request held, never ready
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_o("to_start", O_ST);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk_o("to_wait", O_FRZ);
            tick();
        end
        chk_o("to_release", O_ERR);
        chk_c("to_cnt", 4'd5);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("to_sticky_run", O_ERR);
        tick();
        chk_o("to_sticky_run2", O_ERR);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("to_rst_outs", O_NONE);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("to_err_cleared", O_NONE);
        chk_c("to_cnt_cleared", 4'd0);
        tick();

        // saturation: 20 hazard stalls into a 4-bit counter
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 14) chk_c("sat_14", 4'd14);
            if (i == 15) chk_c("sat_15", 4'd15);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_c("sat_hold", 4'd15);
        tick();
        chk_c("sat_final", 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
